// File: rtl/quad_encoder_multi_if.sv
// rtl/quad_encoder_multi_if.sv - encoder pins, clear strobes and odometry outputs (enc_z only with QENC_INDEX_EN)
interface quad_encoder_multi_if #(
    parameter int N_CH  = 2,
    parameter int POS_W = 32,
    parameter int SPD_W = 16
);
    logic [N_CH-1:0]       enc_a;
    logic [N_CH-1:0]       enc_b;
`ifdef QENC_INDEX_EN
    logic [N_CH-1:0]       enc_z;
`endif
    logic                  pos_clr;
    logic                  err_clr;
    logic [N_CH*POS_W-1:0] position;
    logic [N_CH*SPD_W-1:0] speed;
    logic                  speed_valid;
    logic [N_CH-1:0]       direction;
    logic [N_CH-1:0]       err;

`ifdef QENC_INDEX_EN
    modport master (output enc_a, enc_b, enc_z, pos_clr, err_clr,
                    input  position, speed, speed_valid, direction, err);
    modport slave  (input  enc_a, enc_b, enc_z, pos_clr, err_clr,
                    output position, speed, speed_valid, direction, err);
`else
    modport master (output enc_a, enc_b, pos_clr, err_clr,
                    input  position, speed, speed_valid, direction, err);
    modport slave  (input  enc_a, enc_b, pos_clr, err_clr,
                    output position, speed, speed_valid, direction, err);
`endif
endinterface

// File: rtl/quad_encoder_multi.sv
// rtl/quad_encoder_multi.sv - N-channel x4 quadrature decoder with position, windowed speed, direction, err; index clear under QENC_INDEX_EN
module quad_encoder_multi #(
    parameter int N_CH       = 2,
    parameter int POS_W      = 32,
    parameter int SPD_W      = 16,
    parameter int WINDOW_CYC = 1250000,
    parameter int FILT_LEN   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    quad_encoder_multi_if.slave  bus
);
    localparam int WC_W = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WINDOW_CYC - 1);
    localparam int FC_W = $clog2(FILT_LEN + 1);
    localparam logic [FC_W-1:0] FC_FULL = FC_W'(FILT_LEN);
    localparam logic signed [SPD_W-1:0] SPD_MAX = {1'b0, {(SPD_W-1){1'b1}}};
    localparam logic signed [SPD_W-1:0] SPD_MIN = {1'b1, {(SPD_W-1){1'b0}}};

    // Next {A,B} state when rotating forward (A leads B): 00->10->11->01->00
    function automatic logic [1:0] fwd_next(input logic [1:0] s);
        case (s)
            2'b00:   fwd_next = 2'b10;
            2'b10:   fwd_next = 2'b11;
            2'b11:   fwd_next = 2'b01;
            default: fwd_next = 2'b00;
        endcase
    endfunction

    logic [WC_W-1:0] wcnt;
    logic            win_end;
    logic            sv_q;

    wire [N_CH*POS_W-1:0] pos_flat;
    wire [N_CH*SPD_W-1:0] spd_flat;
    wire [N_CH-1:0]       dir_flat;
    wire [N_CH-1:0]       err_flat;

    assign win_end         = (wcnt == WC_LAST);
    assign bus.position    = pos_flat;
    assign bus.speed       = spd_flat;
    assign bus.speed_valid = sv_q;
    assign bus.direction   = dir_flat;
    assign bus.err         = err_flat;

    // Shared speed window: all channels latch their speed on the same terminal count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt <= '0;
            sv_q <= 1'b0;
        end else begin
            sv_q <= win_end;
            wcnt <= win_end ? '0 : wcnt + WC_W'(1);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [1:0]              s1, s2, cand, ab, prev;
        logic [FC_W-1:0]         cnt, cnt_next;
        logic                    stable, init, chg;
        logic                    up, dn, bad, idx, clr;
        logic [POS_W-1:0]        pos_q;
        logic signed [SPD_W-1:0] acc, acc_sum, spd_q;
        logic                    dir_q, err_q;

        // cnt = number of consecutive identical synchronised samples, saturating at FILT_LEN
        assign cnt_next = (s2 != cand) ? FC_W'(1) :
                          ((cnt == FC_FULL) ? cnt : cnt + FC_W'(1));
        assign stable   = (cnt_next == FC_FULL);

        // Synchroniser and glitch filter; the first stable state only seeds the reference
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s1   <= 2'b00;
                s2   <= 2'b00;
                cand <= 2'b00;
                cnt  <= '0;
                ab   <= 2'b00;
                prev <= 2'b00;
                init <= 1'b0;
                chg  <= 1'b0;
            end else begin
                s1   <= {bus.enc_a[i], bus.enc_b[i]};
                s2   <= s1;
                cand <= s2;
                cnt  <= cnt_next;
                chg  <= 1'b0;
                if (stable) begin
                    if (!init) begin
                        init <= 1'b1;
                        ab   <= s2;
                        prev <= s2;
                    end else if (s2 != ab) begin
                        ab   <= s2;
                        prev <= ab;
                        chg  <= 1'b1;
                    end
                end
            end
        end

        // A change that is neither one step forward nor back flipped both bits
        assign up  = chg && (ab == fwd_next(prev));
        assign dn  = chg && (prev == fwd_next(ab));
        assign bad = chg && !up && !dn;

`ifdef QENC_INDEX_EN
        logic            z1, z2, zcand, zf, zprev;
        logic [FC_W-1:0] zcnt, zcnt_next;

        assign zcnt_next = (z2 != zcand) ? FC_W'(1) :
                           ((zcnt == FC_FULL) ? zcnt : zcnt + FC_W'(1));

        // Index input gets the same synchroniser and filter as A/B
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                z1    <= 1'b0;
                z2    <= 1'b0;
                zcand <= 1'b0;
                zcnt  <= '0;
                zf    <= 1'b0;
                zprev <= 1'b0;
            end else begin
                z1    <= bus.enc_z[i];
                z2    <= z1;
                zcand <= z2;
                zcnt  <= zcnt_next;
                zprev <= zf;
                if (zcnt_next == FC_FULL) zf <= z2;
            end
        end

        assign idx = zf && !zprev && (ab == 2'b00);
`else
        assign idx = 1'b0;
`endif

        assign clr = bus.pos_clr || idx;

        // Position, direction and sticky error; clears beat a same-cycle step
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                pos_q <= '0;
                dir_q <= 1'b0;
                err_q <= 1'b0;
            end else begin
                if (clr)     pos_q <= '0;
                else if (up) pos_q <= pos_q + POS_W'(1);
                else if (dn) pos_q <= pos_q - POS_W'(1);
                if (up)      dir_q <= 1'b1;
                else if (dn) dir_q <= 1'b0;
                if (bad)              err_q <= 1'b1;
                else if (bus.err_clr) err_q <= 1'b0;
            end
        end

        // Saturating window accumulator including this cycle's step
        always_comb begin
            acc_sum = acc;
            if (up && (acc != SPD_MAX))      acc_sum = acc + SPD_W'(1);
            else if (dn && (acc != SPD_MIN)) acc_sum = acc - SPD_W'(1);
        end

        // Hand the window total to speed at terminal count and restart from zero
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                acc   <= '0;
                spd_q <= '0;
            end else if (win_end) begin
                spd_q <= acc_sum;
                acc   <= '0;
            end else begin
                acc   <= acc_sum;
            end
        end

        assign pos_flat[i*POS_W +: POS_W] = pos_q;
        assign spd_flat[i*SPD_W +: SPD_W] = spd_q;
        assign dir_flat[i]                = dir_q;
        assign err_flat[i]                = err_q;
    end
endmodule

// File: tb/tb_quad_encoder_multi.sv
// tb/tb_quad_encoder_multi.sv - scoreboard bench for quad_encoder_multi (index test with QENC_INDEX_EN)
module tb_quad_encoder_multi;
    localparam int N_CH  = 2;
    localparam int POS_W = 8;
    localparam int SPD_W = 16;
    localparam int WIN   = 100;
    localparam int FL    = 4;
    localparam int LAT   = 2 + FL + 1;

    typedef struct { int s0; int s1; } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   sched [2][4096];
    logic [POS_W-1:0] m_pos [2];
    int   m_acc [2];
    logic m_dir [2];
    exp_t expq [$];
    logic [1:0] fseq [4];

    always #5 clk = ~clk;

    quad_encoder_multi_if #(.N_CH(N_CH), .POS_W(POS_W), .SPD_W(SPD_W)) bus ();

    quad_encoder_multi #(
        .N_CH(N_CH), .POS_W(POS_W), .SPD_W(SPD_W), .WINDOW_CYC(WIN), .FILT_LEN(FL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: steps land LAT edges after the pins move; windows close every WIN edges
    always @(posedge clk) begin : model
        int d;
        if (!reset) begin
            cyc = 0;
        end else begin
            cyc = cyc + 1;
            for (int c = 0; c < 2; c++) begin
                d = sched[c][cyc % 4096];
                sched[c][cyc % 4096] = 0;
                if (d != 0) begin
                    m_dir[c] = (d > 0);
                    m_acc[c] = m_acc[c] + d;
                end
                if (bus.pos_clr) m_pos[c] = '0;
                else             m_pos[c] = m_pos[c] + POS_W'(d);
            end
            if (cyc % WIN == 0) begin
                expq.push_back('{m_acc[0], m_acc[1]});
                m_acc[0] = 0;
                m_acc[1] = 0;
            end
        end
    end

    // Scoreboard: speed_valid exactly at window ends, speeds equal to the model's window sums
    always @(negedge clk) begin : monitor
        logic exp_sv;
        exp_t e;
        if (reset && cyc > 0) begin
            exp_sv = (cyc % WIN == 0);
            if (exp_sv || bus.speed_valid) begin
                total++;
                if (bus.speed_valid !== exp_sv) begin
                    bad++;
                    $display("FAIL speed_valid cyc=%0d got=%b want=%b", cyc, bus.speed_valid, exp_sv);
                end
            end
            if (exp_sv && bus.speed_valid) begin
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL scoreboard_empty cyc=%0d got=pulse want=queued entry", cyc);
                end else begin
                    e = expq.pop_front();
                    if (bus.speed[0 +: SPD_W] !== SPD_W'(e.s0)) begin
                        bad++;
                        $display("FAIL speed0 cyc=%0d got=%0d want=%0d", cyc, $signed(bus.speed[0 +: SPD_W]), e.s0);
                    end
                    total++;
                    if (bus.speed[SPD_W +: SPD_W] !== SPD_W'(e.s1)) begin
                        bad++;
                        $display("FAIL speed1 cyc=%0d got=%0d want=%0d", cyc, $signed(bus.speed[SPD_W +: SPD_W]), e.s1);
                    end
                end
            end
        end
    end

    // Drive a new {A,B} on channel c at a falling edge and schedule its model effect
    task automatic step_to(input int c, input logic [1:0] v, input int d, input int hold);
        bus.enc_a[c] = v[1];
        bus.enc_b[c] = v[0];
        sched[c][(cyc + LAT) % 4096] += d;
        repeat (hold) @(negedge clk);
    endtask

    task automatic align(input int r);
        for (int k = 0; k <= WIN && (cyc % WIN) != r; k++) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.position, bus.speed, bus.speed_valid, bus.direction, bus.err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {bus.position, bus.speed, bus.direction, bus.err});
        end
        reset = 1'b1;
        for (int k = 0; k < 200 && cyc < WIN - 1; k++) @(negedge clk);
        total++;
        if (bus.speed_valid !== 1'b0) begin
            bad++;
            $display("FAIL early_speed_valid cyc=%0d got=%b want=0", cyc, bus.speed_valid);
        end
        @(negedge clk);
        total++;
        if (bus.speed_valid !== 1'b1 || bus.speed !== '0) begin
            bad++;
            $display("FAIL first_window cyc=%0d got sv=%b speed=%h want sv=1 speed=0", cyc, bus.speed_valid, bus.speed);
        end
        total++;
        if (bus.position !== '0 || bus.err !== '0) begin
            bad++;
            $display("FAIL idle_state got pos=%h err=%b want 0", bus.position, bus.err);
        end
    endtask

    task automatic test_forward();
        for (int k = 0; k < 160; k++) step_to(0, fseq[(k + 1) % 4], 1, 6);
        repeat (LAT + 2) @(negedge clk);
        total++;
        if (bus.position[0 +: POS_W] !== POS_W'(160)) begin
            bad++;
            $display("FAIL fwd_pos0 got=%0d want=160", bus.position[0 +: POS_W]);
        end
        total++;
        if (bus.direction[0] !== 1'b1) begin
            bad++;
            $display("FAIL fwd_dir0 got=%b want=1", bus.direction[0]);
        end
        total++;
        if (bus.position[POS_W +: POS_W] !== '0 || bus.err !== '0) begin
            bad++;
            $display("FAIL fwd_ch1_quiet got pos1=%h err=%b want 0", bus.position[POS_W +: POS_W], bus.err);
        end
    endtask

    task automatic test_reverse_wrap();
        align(1);
        step_to(1, 2'b01, -1, 6);
        step_to(1, 2'b11, -1, 6);
        step_to(1, 2'b10, -1, 6);
        repeat (LAT + 2) @(negedge clk);
        total++;
        if (bus.position[POS_W +: POS_W] !== 8'hFD) begin
            bad++;
            $display("FAIL rev_pos1 got=%h want=fd", bus.position[POS_W +: POS_W]);
        end
        total++;
        if (bus.direction[1] !== 1'b0) begin
            bad++;
            $display("FAIL rev_dir1 got=%b want=0", bus.direction[1]);
        end
        align(0);
        total++;
        if (bus.speed[SPD_W +: SPD_W] !== 16'hFFFD) begin
            bad++;
            $display("FAIL rev_speed1 got=%0d want=-3", $signed(bus.speed[SPD_W +: SPD_W]));
        end
    endtask

    task automatic test_glitch();
        bus.enc_a[0] = 1'b1;
        repeat (2) @(negedge clk);
        bus.enc_a[0] = 1'b0;
        repeat (12) @(negedge clk);
        total++;
        if (bus.position[0 +: POS_W] !== m_pos[0] || bus.err[0] !== 1'b0) begin
            bad++;
            $display("FAIL glitch got pos0=%0d err0=%b want pos0=%0d err0=0", bus.position[0 +: POS_W], bus.err[0], m_pos[0]);
        end
        step_to(0, 2'b11, 0, 10);
        total++;
        if (bus.err[0] !== 1'b1 || bus.position[0 +: POS_W] !== m_pos[0]) begin
            bad++;
            $display("FAIL illegal got err0=%b pos0=%0d want err0=1 pos0=%0d", bus.err[0], bus.position[0 +: POS_W], m_pos[0]);
        end
        total++;
        if (bus.err[1] !== 1'b0) begin
            bad++;
            $display("FAIL illegal_ch1 got err1=%b want=0", bus.err[1]);
        end
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        total++;
        if (bus.err[0] !== 1'b0) begin
            bad++;
            $display("FAIL err_clr got err0=%b want=0", bus.err[0]);
        end
        step_to(0, 2'b01, 1, 6);
        step_to(0, 2'b00, 1, 6);
        repeat (LAT + 2) @(negedge clk);
        total++;
        if (bus.position[0 +: POS_W] !== 8'd162) begin
            bad++;
            $display("FAIL recover_pos0 got=%0d want=162", bus.position[0 +: POS_W]);
        end
    endtask

    task automatic test_boundary();
        align(1);
        align(WIN - LAT);
        step_to(0, 2'b10, 1, 6);
        @(negedge clk);
        total++;
        if (bus.speed_valid !== 1'b1 || bus.speed[0 +: SPD_W] !== 16'd1) begin
            bad++;
            $display("FAIL terminal_step got sv=%b speed0=%0d want sv=1 speed0=1", bus.speed_valid, $signed(bus.speed[0 +: SPD_W]));
        end
        step_to(0, 2'b11, 1, 6);
        align(0);
        total++;
        if (bus.speed[0 +: SPD_W] !== 16'd1) begin
            bad++;
            $display("FAIL next_window got speed0=%0d want=1", $signed(bus.speed[0 +: SPD_W]));
        end
        step_to(0, 2'b01, 1, 6);
        bus.pos_clr = 1'b1;
        @(negedge clk);
        bus.pos_clr = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.position !== '0) begin
            bad++;
            $display("FAIL pos_clr_wins got=%h want=0", bus.position);
        end
        total++;
        if (bus.position[0 +: POS_W] !== m_pos[0] || bus.direction[0] !== m_dir[0]) begin
            bad++;
            $display("FAIL pos_clr_model got pos0=%0d dir0=%b want pos0=%0d dir0=%b", bus.position[0 +: POS_W], bus.direction[0], m_pos[0], m_dir[0]);
        end
        step_to(0, 2'b00, 1, 6);
    endtask

`ifdef QENC_INDEX_EN
    task automatic test_index();
        step_to(1, 2'b11, 1, 6);
        step_to(1, 2'b01, 1, 6);
        repeat (LAT + 2) @(negedge clk);
        bus.pos_clr = 1'b1;
        @(negedge clk);
        bus.pos_clr = 1'b0;
        for (int k = 0; k < 37; k++) step_to(1, fseq[(k + 4) % 4], 1, 6);
        repeat (LAT + 2) @(negedge clk);
        total++;
        if (bus.position[POS_W +: POS_W] !== 8'd37) begin
            bad++;
            $display("FAIL idx_setup got pos1=%0d want=37", bus.position[POS_W +: POS_W]);
        end
        bus.enc_z[1] = 1'b1;
        repeat (6) @(negedge clk);
        bus.enc_z[1] = 1'b0;
        repeat (12) @(negedge clk);
        m_pos[1] = '0;
        total++;
        if (bus.position[POS_W +: POS_W] !== 8'd0) begin
            bad++;
            $display("FAIL idx_at_00 got pos1=%0d want=0", bus.position[POS_W +: POS_W]);
        end
        step_to(1, 2'b10, 1, 6);
        step_to(1, 2'b11, 1, 6);
        repeat (LAT + 2) @(negedge clk);
        bus.enc_z[1] = 1'b1;
        repeat (6) @(negedge clk);
        bus.enc_z[1] = 1'b0;
        repeat (12) @(negedge clk);
        total++;
        if (bus.position[POS_W +: POS_W] !== 8'd2) begin
            bad++;
            $display("FAIL idx_at_11 got pos1=%0d want=2", bus.position[POS_W +: POS_W]);
        end
    endtask
`endif

    initial begin
        fseq[0] = 2'b00;
        fseq[1] = 2'b10;
        fseq[2] = 2'b11;
        fseq[3] = 2'b01;
        for (int c = 0; c < 2; c++) begin
            m_pos[c] = '0;
            m_acc[c] = 0;
            m_dir[c] = 1'b0;
        end
        bus.enc_a   = '0;
        bus.enc_b   = '0;
        bus.pos_clr = 1'b0;
        bus.err_clr = 1'b0;
`ifdef QENC_INDEX_EN
        bus.enc_z   = '0;
`endif
        @(negedge clk);
        test_reset();
        test_forward();
        test_reverse_wrap();
        test_glitch();
        test_boundary();
`ifdef QENC_INDEX_EN
        test_index();
`endif
        repeat (WIN + LAT + 2) @(negedge clk);
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
